// File: rtl/alu_pkg.sv
// Shared opcode, flag-bit and FSM-state definitions for the ALU issue front end.
package alu_pkg;

    localparam logic [1:0] OP_ADD    = 2'b00;
    localparam logic [1:0] OP_SUB    = 2'b01;
    localparam logic [1:0] OP_AND    = 2'b10;
    localparam logic [1:0] OP_POPCNT = 2'b11;

    localparam int FLG_ZERO  = 2;
    localparam int FLG_CARRY = 1;
    localparam int FLG_OVF   = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/alu_stat_cnt.sv
// Debug statistics: a wrapping completed-op counter and a saturating overflow counter.
module alu_stat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_done,
    input  logic             i_ovf,
    output logic [CNT_W-1:0] o_op_cnt,
    output logic [CNT_W-1:0] o_ovf_cnt
);

    logic [CNT_W-1:0] r_op_cnt;
    logic [CNT_W-1:0] r_ovf_cnt;
    logic             w_ovf_full;

    assign w_ovf_full = &r_ovf_cnt;

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_op_cnt  <= '0;
            r_ovf_cnt <= '0;
        end else if (i_done) begin
            r_op_cnt <= r_op_cnt + CNT_W'(1);
            // Overflow count sticks at all-ones instead of wrapping back to zero
            if (i_ovf && !w_ovf_full)
                r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
        end
    end

    assign o_op_cnt  = r_op_cnt;
    assign o_ovf_cnt = r_ovf_cnt;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Valid/ready front end for the registered ALU: issues one op, captures its result
// two edges later and holds it on the response channel until taken.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [WIDTH-1:0] i_req_arg0,
    input  logic [WIDTH-1:0] i_req_arg1,
    input  logic [1:0]       i_req_oper,
    output logic [WIDTH-1:0] o_alu_arg0,
    output logic [WIDTH-1:0] o_alu_arg1,
    output logic [1:0]       o_alu_oper,
    input  logic [WIDTH-1:0] i_alu_result,
    input  logic [2:0]       i_alu_flag,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [WIDTH-1:0] o_rsp_result,
    output logic [2:0]       o_rsp_flag,
    output logic [CNT_W-1:0] o_op_cnt,
    output logic [CNT_W-1:0] o_ovf_cnt
);

    state_t           r_state;
    state_t           w_next;
    logic             w_accept;
    logic             w_capture;
    logic             w_req_ready;
    logic             w_rsp_valid;
    logic [WIDTH-1:0] r_alu_arg0;
    logic [WIDTH-1:0] r_alu_arg1;
    logic [1:0]       r_alu_oper;
    logic [WIDTH-1:0] r_rsp_result;
    logic [2:0]       r_rsp_flag;

    always_ff @(posedge i_CLK) begin
        if (i_RST)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_req_ready = 1'b0;
        w_rsp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_ready = 1'b1;
                if (i_req_valid) begin
                    w_accept = 1'b1;
                    w_next   = EXEC;
                end
            end
            EXEC: w_next = WAIT;
            // ALU output registered at the previous edge is valid now
            WAIT: begin
                w_capture = 1'b1;
                w_next    = RESP;
            end
            RESP: begin
                w_rsp_valid = 1'b1;
                if (i_rsp_ready)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Operands stay on the ALU inputs after completion; only a new accept replaces them
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_alu_arg0 <= '0;
            r_alu_arg1 <= '0;
            r_alu_oper <= '0;
        end else if (w_accept) begin
            r_alu_arg0 <= i_req_arg0;
            r_alu_arg1 <= i_req_arg1;
            r_alu_oper <= i_req_oper;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_rsp_result <= '0;
            r_rsp_flag   <= '0;
        end else if (w_capture) begin
            r_rsp_result <= i_alu_result;
            r_rsp_flag   <= i_alu_flag;
        end
    end

    alu_stat_cnt #(
        .CNT_W(CNT_W)
    ) u_stat_cnt (
        .i_CLK    (i_CLK),
        .i_RST    (i_RST),
        .i_done   (w_capture),
        .i_ovf    (i_alu_flag[FLG_OVF]),
        .o_op_cnt (o_op_cnt),
        .o_ovf_cnt(o_ovf_cnt)
    );

    assign o_req_ready  = w_req_ready;
    assign o_rsp_valid  = w_rsp_valid;
    assign o_alu_arg0   = r_alu_arg0;
    assign o_alu_arg1   = r_alu_arg1;
    assign o_alu_oper   = r_alu_oper;
    assign o_rsp_result = r_rsp_result;
    assign o_rsp_flag   = r_rsp_flag;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized bench for alu_issue_ctrl with a behavioural registered-ALU stub and scoreboard.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int W    = 8;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          i_RST;
    logic          i_req_valid;
    logic          o_req_ready;
    logic [W-1:0]  i_req_arg0, i_req_arg1;
    logic [1:0]    i_req_oper;
    logic [W-1:0]  o_alu_arg0, o_alu_arg1;
    logic [1:0]    o_alu_oper;
    logic [W-1:0]  alu_result;
    logic [2:0]    alu_flag;
    logic          o_rsp_valid;
    logic          i_rsp_ready;
    logic [W-1:0]  o_rsp_result;
    logic [2:0]    o_rsp_flag;
    logic [CW-1:0] o_op_cnt, o_ovf_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int ops_m   = 0;
    int ovf_m   = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .i_CLK       (clk),
        .i_RST       (i_RST),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_arg0  (i_req_arg0),
        .i_req_arg1  (i_req_arg1),
        .i_req_oper  (i_req_oper),
        .o_alu_arg0  (o_alu_arg0),
        .o_alu_arg1  (o_alu_arg1),
        .o_alu_oper  (o_alu_oper),
        .i_alu_result(alu_result),
        .i_alu_flag  (alu_flag),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_result(o_rsp_result),
        .o_rsp_flag  (o_rsp_flag),
        .o_op_cnt    (o_op_cnt),
        .o_ovf_cnt   (o_ovf_cnt)
    );

    function automatic void alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [1:0] op,
                                      output logic [W-1:0] res, output logic [2:0] flg);
        int u, s;
        int carry, ovf;
        carry = 0;
        ovf   = 0;
        case (op)
            OP_ADD: begin
                u = int'(a) + int'(b);
                s = int'($signed(a)) + int'($signed(b));
                carry = (u > 255) ? 1 : 0;
                ovf   = (s > 127 || s < -128) ? 1 : 0;
            end
            OP_SUB: begin
                u = int'(a) - int'(b);
                s = int'($signed(a)) - int'($signed(b));
                carry = (a < b) ? 1 : 0;
                ovf   = (s > 127 || s < -128) ? 1 : 0;
            end
            OP_AND:  u = int'(a & b);
            default: u = $countones(a) + $countones(b);
        endcase
        res = W'(u & 255);
        flg = {(res == '0), (carry != 0), (ovf != 0)};
    endfunction

    always @(posedge clk) begin
        if (i_RST) begin
            alu_result <= '0;
            alu_flag   <= '0;
        end else begin
            alu_model(o_alu_arg0, o_alu_arg1, o_alu_oper, alu_result, alu_flag);
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_op();
        return 32'(ops_m % (CMAX + 1));
    endfunction

    function automatic logic [31:0] exp_ovf();
        return 32'((ovf_m > CMAX) ? CMAX : ovf_m);
    endfunction

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] op, input int bp);
        logic [W-1:0] er;
        logic [2:0]   ef;
        alu_model(a, b, op, er, ef);
        chk("req_ready_idle", 32'(o_req_ready), 1);
        i_req_valid = 1'b1;
        i_req_arg0  = a;
        i_req_arg1  = b;
        i_req_oper  = op;
        @(negedge clk);
        i_req_valid = 1'b0;
        i_req_arg0  = W'($urandom);
        i_req_arg1  = W'($urandom);
        i_req_oper  = 2'($urandom);
        chk("exec_rsp_valid", 32'(o_rsp_valid), 0);
        chk("exec_req_ready", 32'(o_req_ready), 0);
        chk("alu_arg0", 32'(o_alu_arg0), 32'(a));
        chk("alu_arg1", 32'(o_alu_arg1), 32'(b));
        chk("alu_oper", 32'(o_alu_oper), 32'(op));
        @(negedge clk);
        chk("wait_rsp_valid", 32'(o_rsp_valid), 0);
        i_rsp_ready = (bp == 0);
        i_req_valid = (bp > 0);
        @(negedge clk);
        ops_m++;
        if (ef[FLG_OVF]) ovf_m++;
        chk("rsp_valid", 32'(o_rsp_valid), 1);
        chk("rsp_result", 32'(o_rsp_result), 32'(er));
        chk("rsp_flag", 32'(o_rsp_flag), 32'(ef));
        chk("op_cnt", 32'(o_op_cnt), exp_op());
        chk("ovf_cnt", 32'(o_ovf_cnt), exp_ovf());
        for (int k = 1; k < bp; k++) begin
            i_req_arg0 = W'($urandom);
            i_req_oper = 2'($urandom);
            @(negedge clk);
            chk("bp_rsp_valid", 32'(o_rsp_valid), 1);
            chk("bp_rsp_result", 32'(o_rsp_result), 32'(er));
            chk("bp_rsp_flag", 32'(o_rsp_flag), 32'(ef));
            chk("bp_req_ready", 32'(o_req_ready), 0);
            chk("bp_op_cnt", 32'(o_op_cnt), exp_op());
        end
        i_rsp_ready = 1'b1;
        i_req_valid = 1'b0;
        @(negedge clk);
        chk("done_rsp_valid", 32'(o_rsp_valid), 0);
        chk("done_req_ready", 32'(o_req_ready), 1);
        chk("keep_alu_arg0", 32'(o_alu_arg0), 32'(a));
    endtask

    task automatic idle_gap(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("gap_rsp_valid", 32'(o_rsp_valid), 0);
            chk("gap_req_ready", 32'(o_req_ready), 1);
        end
    endtask

    // stage: 1 = reset while EXEC, 2 = WAIT, 3 = RESP
    task automatic reset_mid(input int stage);
        i_req_valid = 1'b1;
        i_req_arg0  = 8'h7F;
        i_req_arg1  = 8'h01;
        i_req_oper  = OP_ADD;
        @(negedge clk);
        i_req_valid = 1'b0;
        for (int k = 1; k < stage; k++) @(negedge clk);
        i_RST = 1'b1;
        @(negedge clk);
        i_RST = 1'b0;
        ops_m = 0;
        ovf_m = 0;
        chk("rst_req_ready", 32'(o_req_ready), 1);
        chk("rst_rsp_valid", 32'(o_rsp_valid), 0);
        chk("rst_op_cnt", 32'(o_op_cnt), 0);
        chk("rst_ovf_cnt", 32'(o_ovf_cnt), 0);
        chk("rst_rsp_result", 32'(o_rsp_result), 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("drop_rsp_valid", 32'(o_rsp_valid), 0);
            chk("drop_op_cnt", 32'(o_op_cnt), 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    end

    initial begin
        logic [W-1:0] a, b;
        logic [1:0]   op;
        int           bp;
        i_RST       = 1'b1;
        i_req_valid = 1'b0;
        i_req_arg0  = '0;
        i_req_arg1  = '0;
        i_req_oper  = '0;
        i_rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 32'(o_req_ready), 1);
        chk("reset_rsp_valid", 32'(o_rsp_valid), 0);
        chk("reset_alu_arg0", 32'(o_alu_arg0), 0);
        chk("reset_rsp_result", 32'(o_rsp_result), 0);
        chk("reset_rsp_flag", 32'(o_rsp_flag), 0);
        chk("reset_op_cnt", 32'(o_op_cnt), 0);
        chk("reset_ovf_cnt", 32'(o_ovf_cnt), 0);
        i_RST = 1'b0;
        @(negedge clk);

        do_op(8'h7F, 8'h01, OP_ADD, 0);
        do_op(8'h00, 8'h01, OP_SUB, 0);
        do_op(8'hF0, 8'h0F, OP_AND, 0);
        do_op(8'hFF, 8'h01, OP_POPCNT, 0);
        do_op(8'h12, 8'h34, OP_ADD, 5);
        do_op(8'h80, 8'h01, OP_SUB, 0);
        reset_mid(2);

        for (int i = 0; i < 20; i++) begin
            bp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            do_op(8'h40 + W'($urandom_range(0, 63)), 8'h40, OP_ADD, bp);
        end
        reset_mid(1);
        reset_mid(3);

        for (int i = 0; i < 60; i++) begin
            a  = W'($urandom);
            b  = W'($urandom);
            op = 2'($urandom);
            bp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
            do_op(a, b, op, bp);
            idle_gap(int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
